lynx_tap_player: RTL and testbench

- Cassette playback controller for the Lynx core.
- Captures a TAP file streamed over the HPS ioctl interface into an internal byte buffer.
- On command, sequences playback as a square-wave EAR signal: leader, sync, then data bits.
- Drives the core's tape input, muxing between the playback waveform and the ADC EAR input.

---
 rtl/lynx_tap_player_if.sv | 17 +
 rtl/lynx_tap_player.sv | 244 ++++++++++++++++++++++++
 tb/tb_lynx_tap_player.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lynx_tap_player_if.sv
`default_nettype none
// ============================================================================
// Module   : lynx_tap_player_if
// Purpose  : HPS ioctl download bus carrying TAP file bytes to the player.
// Revision : 1.0 - initial release
// ============================================================================
interface lynx_tap_player_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;

  modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data);
  modport slave  (input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data);
endinterface
`default_nettype wire

// File: rtl/lynx_tap_player.sv
`default_nettype none
// ============================================================================
// Module   : lynx_tap_player
// Purpose  : Captures a TAP image from the ioctl bus into a byte buffer and
//            replays it as a square-wave EAR signal (leader, sync, data bits).
// Revision : 1.0 - initial release
// ============================================================================
module lynx_tap_player #(
  parameter logic [7:0] TAP_INDEX     = 8'h01,
  parameter int         ADDR_W        = 16,
  parameter int         T0_HALF       = 2400,
  parameter int         T1_HALF       = 4800,
  parameter int         SYNC_HALF     = 9600,
  parameter int         LEADER_CYCLES = 768
) (
  input  logic              clk_sys,
  input  logic              reset,
  lynx_tap_player_if.slave  ioctl,
  input  logic              play,
  input  logic              stop,
  input  logic              motor,
  input  logic              ear_adc,
  output logic              ear,
  output logic              tape_active,
  output logic              loaded,
  output logic              overflow,
  output logic [ADDR_W-1:0] progress
);

  localparam int MAX_T01  = (T0_HALF > T1_HALF) ? T0_HALF : T1_HALF;
  localparam int MAX_HALF = (MAX_T01 > SYNC_HALF) ? MAX_T01 : SYNC_HALF;
  localparam int CNT_W    = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
  localparam int LC_W     = (LEADER_CYCLES > 1) ? $clog2(LEADER_CYCLES) : 1;
  localparam int DEPTH    = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] T0_RELOAD   = CNT_W'(T0_HALF - 1);
  localparam logic [CNT_W-1:0] T1_RELOAD   = CNT_W'(T1_HALF - 1);
  localparam logic [CNT_W-1:0] SYNC_RELOAD = CNT_W'(SYNC_HALF - 1);
  localparam logic [LC_W-1:0]  LEADER_LAST = LC_W'(LEADER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_LEADER = 3'd3,
    S_SYNC   = 3'd4,
    S_DATA   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t            state, state_next;
  logic              tape_level, level_next;
  logic              active_next, loaded_next, overflow_next;
  logic [ADDR_W-1:0] progress_next;
  logic [ADDR_W:0]   len, len_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [LC_W-1:0]   lcnt, lcnt_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift, shift_next;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_data;
  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr;

  logic              tap_sel;
  logic              in_range;
  logic [24:0]       addr_hi;
  logic [ADDR_W:0]   len_cand;
  logic              last_byte;
  logic              cur_bit;

  // Half-period reload for a data bit value
  function automatic logic [CNT_W-1:0] bit_half(input logic b);
    return b ? T1_RELOAD : T0_RELOAD;
  endfunction

  assign tap_sel   = ioctl.ioctl_download && (ioctl.ioctl_index == TAP_INDEX);
  assign addr_hi   = ioctl.ioctl_addr >> ADDR_W;
  assign in_range  = (addr_hi == '0);
  assign len_cand  = (ADDR_W+1)'(ioctl.ioctl_addr[ADDR_W-1:0]) + (ADDR_W+1)'(1);
  assign last_byte = ((ADDR_W+1)'(progress) + (ADDR_W+1)'(1)) == len;
  assign cur_bit   = shift[bit_idx];

  // Tape input mux: playback waveform while active, otherwise the ADC input
  assign ear = tape_active ? tape_level : ear_adc;

  // State and playback registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      tape_level  <= 1'b0;
      tape_active <= 1'b0;
      loaded      <= 1'b0;
      overflow    <= 1'b0;
      progress    <= '0;
      len         <= '0;
      cnt         <= '0;
      lcnt        <= '0;
      bit_idx     <= '0;
      shift       <= '0;
    end else begin
      state       <= state_next;
      tape_level  <= level_next;
      tape_active <= active_next;
      loaded      <= loaded_next;
      overflow    <= overflow_next;
      progress    <= progress_next;
      len         <= len_next;
      cnt         <= cnt_next;
      lcnt        <= lcnt_next;
      bit_idx     <= bit_next;
      shift       <= shift_next;
    end
  end

  // Byte buffer: ioctl write port, registered read port (one-cycle latency)
  always_ff @(posedge clk_sys) begin
    if (wr_en && !reset) begin
      mem[ioctl.ioctl_addr[ADDR_W-1:0]] <= ioctl.ioctl_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  // Next-state logic: download capture, start/stop, half-period engine
  always_comb begin
    state_next    = state;
    level_next    = tape_level;
    active_next   = tape_active;
    loaded_next   = loaded;
    overflow_next = overflow;
    progress_next = progress;
    len_next      = len;
    cnt_next      = cnt;
    lcnt_next     = lcnt;
    bit_next      = bit_idx;
    shift_next    = shift;
    rd_en         = 1'b0;
    rd_addr       = progress + ADDR_W'(1);
    wr_en         = 1'b0;

    if (tap_sel && state != S_LOAD) begin
      // A new TAP download aborts whatever was going on
      state_next    = S_LOAD;
      level_next    = 1'b0;
      active_next   = 1'b0;
      loaded_next   = 1'b0;
      overflow_next = 1'b0;
      len_next      = '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (!ioctl.ioctl_download) begin
            state_next  = S_READY;
            loaded_next = (len != '0);
          end else if (ioctl.ioctl_wr) begin
            if (in_range) begin
              wr_en = 1'b1;
              if (len_cand > len) len_next = len_cand;
            end else begin
              overflow_next = 1'b1;
            end
          end
        end

        S_READY, S_DONE: begin
          if (play && !stop && loaded) begin
            state_next    = S_LEADER;
            level_next    = 1'b1;
            active_next   = 1'b1;
            cnt_next      = T0_RELOAD;
            lcnt_next     = '0;
            progress_next = '0;
            rd_en         = 1'b1;
            rd_addr       = '0;
          end
        end

        S_LEADER, S_SYNC, S_DATA: begin
          if (stop) begin
            state_next  = S_READY;
            active_next = 1'b0;
            level_next  = 1'b0;
          end else if (motor) begin
            if (cnt != '0) begin
              cnt_next = cnt - CNT_W'(1);
            end else if (tape_level) begin
              // End of a high half: the low half has the same length
              level_next = 1'b0;
              case (state)
                S_LEADER: cnt_next = T0_RELOAD;
                S_SYNC:   cnt_next = SYNC_RELOAD;
                default:  cnt_next = bit_half(cur_bit);
              endcase
            end else begin
              // End of a low half: one full cycle is complete
              level_next = 1'b1;
              case (state)
                S_LEADER: begin
                  if (lcnt == LEADER_LAST) begin
                    state_next = S_SYNC;
                    cnt_next   = SYNC_RELOAD;
                  end else begin
                    lcnt_next  = lcnt + LC_W'(1);
                    cnt_next   = T0_RELOAD;
                  end
                end
                S_SYNC: begin
                  state_next = S_DATA;
                  shift_next = rd_data;
                  bit_next   = 3'd7;
                  cnt_next   = bit_half(rd_data[7]);
                end
                default: begin
                  if (bit_idx != 3'd0) begin
                    bit_next = bit_idx - 3'd1;
                    cnt_next = bit_half(shift[bit_idx - 3'd1]);
                    // Prefetch the following byte as bit 0 starts
                    if (bit_idx == 3'd1) rd_en = 1'b1;
                  end else if (last_byte) begin
                    state_next  = S_DONE;
                    level_next  = 1'b0;
                    active_next = 1'b0;
                  end else begin
                    progress_next = progress + ADDR_W'(1);
                    shift_next    = rd_data;
                    bit_next      = 3'd7;
                    cnt_next      = bit_half(rd_data[7]);
                  end
                end
              endcase
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lynx_tap_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_lynx_tap_player
// Purpose  : Self-checking bench for lynx_tap_player with a waveform model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lynx_tap_player;

  localparam logic [7:0] TAP    = 8'h01;
  localparam int         AW     = 4;
  localparam int         CAP    = 1 << AW;
  localparam int         T0     = 4;
  localparam int         T1     = 8;
  localparam int         SYNC   = 16;
  localparam int         LEADER = 2;

  logic          clk = 1'b0;
  logic          reset, play, stop, motor, ear_adc;
  logic          ear, tape_active, loaded, overflow;
  logic [AW-1:0] progress;

  lynx_tap_player_if bus ();

  lynx_tap_player #(
    .TAP_INDEX(TAP), .ADDR_W(AW), .T0_HALF(T0), .T1_HALF(T1),
    .SYNC_HALF(SYNC), .LEADER_CYCLES(LEADER)
  ) dut (
    .clk_sys(clk), .reset(reset), .ioctl(bus.slave), .play(play), .stop(stop),
    .motor(motor), .ear_adc(ear_adc), .ear(ear), .tape_active(tape_active),
    .loaded(loaded), .overflow(overflow), .progress(progress)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_mem [CAP];
  int         model_len = 0;
  bit         model_loaded = 0;
  bit         model_ovf = 0;
  logic [7:0] src [$];
  bit         exp_lvl [$];
  int         exp_byte [$];

  task automatic tick();
    ear_adc = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Expected playback as one entry per clock: level and byte being played
  task automatic push_seg(input bit lvl, input int n, input int b);
    repeat (n) begin
      exp_lvl.push_back(lvl);
      exp_byte.push_back(b);
    end
  endtask

  task automatic build_wave();
    exp_lvl.delete();
    exp_byte.delete();
    for (int c = 0; c < LEADER; c++) begin
      push_seg(1'b1, T0, 0);
      push_seg(1'b0, T0, 0);
    end
    push_seg(1'b1, SYNC, 0);
    push_seg(1'b0, SYNC, 0);
    for (int b = 0; b < model_len; b++) begin
      for (int k = 7; k >= 0; k--) begin
        int h;
        h = model_mem[b][k] ? T1 : T0;
        push_seg(1'b1, h, b);
        push_seg(1'b0, h, b);
      end
    end
  endtask

  // Stream src[] over the ioctl bus with the given index, then check flags
  task automatic load_file(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < src.size(); a++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(a);
      bus.ioctl_data = src[a];
      tick();
      bus.ioctl_wr = 1'b0;
      if ($urandom_range(0, 2) == 0) tick();
    end
    bus.ioctl_download = 1'b0;
    tick();
    if (idx == TAP) begin
      model_len = (src.size() > CAP) ? CAP : src.size();
      for (int a = 0; a < model_len; a++) model_mem[a] = src[a];
      model_ovf    = (src.size() > CAP);
      model_loaded = (model_len != 0);
    end
    vectors++;
    if (loaded !== model_loaded || overflow !== model_ovf || tape_active !== 1'b0 || ear !== ear_adc) begin
      miscompares++;
      $display("FAIL load idx=%0d: loaded=%b overflow=%b active=%b ear=%b, required loaded=%b overflow=%b active=0 ear=%b",
               idx, loaded, overflow, tape_active, ear, model_loaded, model_ovf, ear_adc);
    end
  endtask

  // Play the buffer and compare every cycle to the model.
  // act_kind: 0 none, 1 stop at step act_at, 2 reset at step act_at.
  task automatic run_play(input int act_at, input int act_kind, input int pause_at,
                          input int pause_len, input bit rnd);
    int i, n, pause_left, guard;
    bit m, used, fin;
    build_wave();
    n = exp_lvl.size();
    motor = 1'b1;
    play  = 1'b1;
    tick();
    play = 1'b0;
    i = 0; pause_left = 0; guard = 0; used = 0; fin = 0;
    while (!fin) begin
      vectors++;
      if (i < n) begin
        if (tape_active !== 1'b1 || ear !== exp_lvl[i] || progress !== AW'(exp_byte[i])) begin
          miscompares++;
          $display("FAIL play step %0d: active=%b ear=%b progress=%0d, required active=1 ear=%b progress=%0d",
                   i, tape_active, ear, progress, exp_lvl[i], exp_byte[i]);
        end
      end else begin
        if (tape_active !== 1'b0 || ear !== ear_adc || progress !== AW'(model_len - 1)) begin
          miscompares++;
          $display("FAIL play done: active=%b ear=%b progress=%0d, required active=0 ear=%b progress=%0d",
                   tape_active, ear, progress, ear_adc, model_len - 1);
        end
        fin = 1;
      end
      if (!fin && i == act_at && act_kind != 0) begin
        if (act_kind == 1) stop = 1'b1; else reset = 1'b1;
        tick();
        stop = 1'b0; reset = 1'b0;
        vectors++;
        if (act_kind == 1) begin
          if (tape_active !== 1'b0 || ear !== ear_adc) begin
            miscompares++;
            $display("FAIL stop: active=%b ear=%b, required active=0 ear=%b", tape_active, ear, ear_adc);
          end
        end else begin
          model_loaded = 0;
          model_ovf    = 0;
          if (tape_active !== 1'b0 || ear !== ear_adc || loaded !== 1'b0 || progress !== '0) begin
            miscompares++;
            $display("FAIL reset mid-play: active=%b ear=%b loaded=%b progress=%0d, required 0 %b 0 0",
                     tape_active, ear, loaded, progress, ear_adc);
          end
        end
        fin = 1;
      end
      if (!fin) begin
        m = 1'b1;
        if (pause_left > 0) begin
          m = 1'b0; pause_left--;
        end else if (i == pause_at && !used) begin
          used = 1; m = 1'b0; pause_left = pause_len - 1;
        end else if (rnd && $urandom_range(0, 49) == 0) begin
          m = 1'b0; pause_left = $urandom_range(0, 5);
        end
        motor = m;
        tick();
        if (m) i++;
        guard++;
        if (guard > 5000) begin
          vectors++;
          miscompares++;
          $display("FAIL play timeout: step %0d of %0d", i, n);
          fin = 1;
        end
      end
    end
    motor = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if (tape_active !== 1'b0 || loaded !== 1'b0 || overflow !== 1'b0 || progress !== '0 || ear !== ear_adc) begin
      miscompares++;
      $display("FAIL reset: active=%b loaded=%b overflow=%b progress=%0d ear=%b, required 0 0 0 0 ear=%b",
               tape_active, loaded, overflow, progress, ear, ear_adc);
    end
    play = 1'b1; tick(); play = 1'b0; tick();
    vectors++;
    if (tape_active !== 1'b0 || ear !== ear_adc) begin
      miscompares++;
      $display("FAIL play unloaded: active=%b ear=%b, required active=0 ear=%b", tape_active, ear, ear_adc);
    end
  endtask

  task automatic test_load();
    src = '{8'hA5, 8'h00, 8'hFF};
    load_file(TAP);
  endtask

  task automatic test_timing();
    run_play(-1, 0, -1, 0, 0);
  endtask

  task automatic test_pause();
    // Step 164 lies inside byte 1 for this leader/sync setup
    run_play(-1, 0, 164, 50, 0);
  endtask

  task automatic test_stop();
    run_play(60, 1, -1, 0, 0);
    play = 1'b1; stop = 1'b1;
    tick();
    play = 1'b0; stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (tape_active !== 1'b0 || ear !== ear_adc) begin
        miscompares++;
        $display("FAIL play+stop: active=%b ear=%b, required active=0 ear=%b", tape_active, ear, ear_adc);
      end
      tick();
    end
    run_play(-1, 0, -1, 0, 1);
  endtask

  task automatic test_overflow();
    src.delete();
    for (int a = 0; a < 20; a++) src.push_back(8'($urandom));
    load_file(TAP);
    run_play(-1, 0, -1, 0, 1);
    src.delete();
    for (int a = 0; a < 5; a++) src.push_back(8'($urandom));
    load_file(8'h00);
    run_play(-1, 0, -1, 0, 0);
  endtask

  task automatic test_reset_midplay();
    run_play(2 * LEADER * T0 + 5, 2, -1, 0, 0);
  endtask

  task automatic test_random();
    repeat (4) begin
      src.delete();
      repeat ($urandom_range(1, CAP)) src.push_back(8'($urandom));
      load_file(TAP);
      run_play(-1, 0, -1, 0, 1);
    end
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; stop = 1'b0; motor = 1'b1; ear_adc = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'h00; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_data = '0;
    test_reset();
    test_load();
    test_timing();
    test_pause();
    test_stop();
    test_overflow();
    test_reset_midplay();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
